// File: rtl/channel_encoder_pkg.sv
// Shared constants and helpers for the four-channel instruction word format.
// Imported by the encoder (and intended for the matching decoder) so both
// sides agree on field positions and widths.
//
// Word layout: [15:14] opcode, [13:12] channel select, [11:0] payload.
package chan_enc_pkg;

  localparam int NUM_CH  = 4;
  localparam int SEL_W   = 2;
  localparam int DATA_W  = 12;
  localparam int WORD_W  = 16;
  localparam int SEL_LSB = 12;
  localparam int OPC_LSB = 14;

  // Assemble one instruction word from its three fields.
  function automatic logic [WORD_W-1:0] pack_word(
    input logic [WORD_W-OPC_LSB-1:0] opc,
    input logic [SEL_W-1:0]          sel,
    input logic [DATA_W-1:0]         payload
  );
    return {opc, sel, payload};
  endfunction

endpackage

// File: rtl/channel_encoder_if.sv
// Valid/ready stream carrying encoded instruction words.
//   out_word  : instruction word {opcode, sel, payload}
//   out_valid : out_word is valid
//   out_ready : sink accepts out_word this cycle
// master = encoder side, slave = decoder / downstream side.
interface channel_encoder_if;
  import chan_enc_pkg::*;

  logic [WORD_W-1:0] out_word;
  logic              out_valid;
  logic              out_ready;

  modport master (output out_word, output out_valid, input out_ready);
  modport slave  (input out_word, input out_valid, output out_ready);

endinterface

// File: rtl/channel_encoder_rr_arb4.sv
// Combinational 4-way round-robin arbiter.
//   req[3:0]     : request bits
//   last[1:0]    : index granted most recently
//   gnt_idx[1:0] : first requester searching last+1, last+2, ... modulo 4
//   gnt_any      : at least one request present (gnt_idx meaningful)
module rr_arb4 (
  input  logic [3:0] req,
  input  logic [1:0] last,
  output logic [1:0] gnt_idx,
  output logic       gnt_any
);

  // NOTE: every output gets a default before the search loop so no path
  // leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    logic [1:0] cand;
    gnt_idx = last;
    gnt_any = 1'b0;
    cand    = last;
    for (int k = 1; k <= 4; k++) begin
      // 2-bit wraparound gives the modulo-4 rotation for free.
      cand = last + k[1:0];
      if (!gnt_any && req[cand]) begin
        gnt_idx = cand;
        gnt_any = 1'b1;
      end
    end
  end

endmodule

// File: rtl/channel_encoder.sv
// Four-channel instruction encoder: captures per-channel 12-bit values on
// update strobes, keeps one pending update per channel, and serialises them
// round-robin as 16-bit instruction words over a valid/ready stream.
//   clk, rst     : clock, synchronous active-high reset
//   ch_data      : four packed channel values, channel i at [12*i +: 12]
//   ch_upd       : per-channel capture strobe
//   refresh      : pulse, re-queue all four held values
//   clr_overrun  : clear the sticky overrun flags
//   stream       : output word stream (master side)
//   overrun      : sticky, an update replaced a value that was never sent
//   busy         : work pending or a word is presented
module channel_encoder #(
  parameter int         DATA_W = 12,
  parameter logic [1:0] OPCODE = 2'b00
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [4*DATA_W-1:0]   ch_data,
  input  logic [3:0]            ch_upd,
  input  logic                  refresh,
  input  logic                  clr_overrun,
  channel_encoder_if.master     stream,
  output logic [3:0]            overrun,
  output logic                  busy
);
  import chan_enc_pkg::NUM_CH;
  import chan_enc_pkg::SEL_W;
  import chan_enc_pkg::pack_word;

  // The word format leaves exactly 12 payload bits.
  if (DATA_W != chan_enc_pkg::DATA_W) begin : g_bad_width
    $error("channel_encoder: DATA_W must be 12");
  end

  logic [DATA_W-1:0] hold [NUM_CH];
  logic [NUM_CH-1:0] pend;
  logic [SEL_W-1:0]  last;
  logic [SEL_W-1:0]  gnt_idx;
  logic              gnt_any;
  logic              load;
  logic [NUM_CH-1:0] gnt_oh;
  logic [NUM_CH-1:0] ovr_evt;

  rr_arb4 u_arb (
    .req     (pend),
    .last    (last),
    .gnt_idx (gnt_idx),
    .gnt_any (gnt_any)
  );

  // Output register is free when empty or being drained this cycle.
  assign load = (!stream.out_valid || stream.out_ready) && gnt_any;

  always_comb begin
    gnt_oh = '0;
    if (load) gnt_oh[gnt_idx] = 1'b1;
  end

  // A channel being loaded this cycle has its old value on its way out, so a
  // simultaneous update is not an overwrite of unsent data.
  assign ovr_evt = ch_upd & pend & ~gnt_oh;

  assign busy = (|pend) || stream.out_valid;

  // NOTE: state uses non-blocking assignments so every register samples the
  // pre-edge values; here hold[gnt_idx] must be read before it is recaptured.
  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: the small hold array is reset explicitly because its contents
      // become visible on the bus after a refresh.
      for (int i = 0; i < NUM_CH; i++) hold[i] <= '0;
      pend             <= '0;
      last             <= SEL_W'(NUM_CH - 1);
      overrun          <= '0;
      stream.out_word  <= '0;
      stream.out_valid <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (ch_upd[i]) hold[i] <= ch_data[DATA_W*i +: DATA_W];
      end
      // Update or refresh re-arms a channel even if it is granted this cycle.
      pend    <= ch_upd | {NUM_CH{refresh}} | (pend & ~gnt_oh);
      overrun <= clr_overrun ? ovr_evt : (overrun | ovr_evt);

      if (load) begin
        stream.out_word  <= pack_word(OPCODE, gnt_idx, hold[gnt_idx]);
        stream.out_valid <= 1'b1;
        last             <= gnt_idx;
      end else if (stream.out_ready) begin
        // Accepted with nothing queued; the word itself is left as is.
        stream.out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_channel_encoder.sv
// Self-checking bench for channel_encoder: directed scenarios followed by a
// randomized phase, all compared cycle by cycle against a behavioural model.
module tb_channel_encoder;
  import chan_enc_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic [47:0] ch_data;
  logic [3:0]  ch_upd;
  logic        refresh;
  logic        clr_overrun;
  logic [3:0]  overrun;
  logic        busy;

  channel_encoder_if sif ();

  channel_encoder dut (
    .clk         (clk),
    .rst         (rst),
    .ch_data     (ch_data),
    .ch_upd      (ch_upd),
    .refresh     (refresh),
    .clr_overrun (clr_overrun),
    .stream      (sif.master),
    .overrun     (overrun),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  // ---------------- behavioural reference model ----------------
  logic [11:0] m_hold [4];
  bit          m_pend [4];
  int          m_last;
  logic [15:0] m_word;
  bit          m_valid;
  logic [3:0]  m_ov;

  task automatic model_step();
    bit         any;
    bit         ld;
    int         g;
    logic [3:0] evt;
    if (rst) begin
      for (int i = 0; i < 4; i++) begin
        m_hold[i] = '0;
        m_pend[i] = 1'b0;
      end
      m_last = 3; m_word = '0; m_valid = 1'b0; m_ov = '0;
      return;
    end
    any = 1'b0; g = 0;
    for (int k = 1; k <= 4; k++) begin
      int idx;
      idx = (m_last + k) % 4;
      if (!any && m_pend[idx]) begin g = idx; any = 1'b1; end
    end
    ld = (!m_valid || sif.out_ready) && any;
    for (int i = 0; i < 4; i++)
      evt[i] = ch_upd[i] && m_pend[i] && !(ld && g == i);
    if (ld) begin
      m_word  = {2'b00, 2'(g), m_hold[g]};
      m_valid = 1'b1;
      m_last  = g;
      m_pend[g] = 1'b0;
    end else if (m_valid && sif.out_ready) begin
      m_valid = 1'b0;
    end
    if (refresh) for (int i = 0; i < 4; i++) m_pend[i] = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (ch_upd[i]) begin
        m_hold[i] = ch_data[12*i +: 12];
        m_pend[i] = 1'b1;
      end
    end
    m_ov = clr_overrun ? evt : (m_ov | evt);
  endtask

  function automatic bit model_busy();
    bit b;
    b = m_valid;
    for (int i = 0; i < 4; i++) b = b | m_pend[i];
    return b;
  endfunction

  // One clock: model advances on the edge, DUT compared 1 ns later.
  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    check("word",    32'(sif.out_word),  32'(m_word));
    check("valid",   32'(sif.out_valid), 32'(m_valid));
    check("overrun", 32'(overrun),       32'(m_ov));
    check("busy",    32'(busy),          32'(model_busy()));
  endtask

  task automatic idle();
    ch_upd = '0; refresh = 1'b0; clr_overrun = 1'b0; rst = 1'b0;
  endtask

  task automatic do_reset();
    idle(); rst = 1'b1; tick(); rst = 1'b0;
  endtask

  task automatic upd(input int ch, input logic [11:0] v);
    ch_data[12*ch +: 12] = v;
    ch_upd[ch] = 1'b1;
  endtask

  logic [15:0] exp_words [4];

  initial begin
    idle(); ch_data = '0; sif.out_ready = 1'b1;
    #2;

    // Reset state
    do_reset();
    check("rst_word",  32'(sif.out_word), 32'h0);
    check("rst_valid", 32'(sif.out_valid), 32'h0);
    check("rst_busy",  32'(busy), 32'h0);

    // Single update: valid only in cycle 2
    upd(2, 12'hABC); tick();
    idle();
    check("single_c1_valid", 32'(sif.out_valid), 32'h0);
    tick();
    check("single_word",  32'(sif.out_word), 32'h2ABC);
    check("single_valid", 32'(sif.out_valid), 32'h1);
    tick();
    check("single_drop", 32'(sif.out_valid), 32'h0);
    check("single_busy", 32'(busy), 32'h0);

    // Fairness from reset
    do_reset();
    upd(0, 12'h111); upd(1, 12'h222); upd(2, 12'h333); upd(3, 12'h444);
    tick(); idle();
    exp_words = '{16'h0111, 16'h1222, 16'h2333, 16'h3444};
    for (int i = 0; i < 4; i++) begin
      tick();
      check("fair_word", 32'(sif.out_word), 32'(exp_words[i]));
    end
    tick();
    check("fair_done", 32'(sif.out_valid), 32'h0);

    // Backpressure
    do_reset();
    sif.out_ready = 1'b0;
    upd(1, 12'h555); tick(); idle(); tick();
    for (int i = 0; i < 5; i++) begin
      tick();
      check("bp_word",  32'(sif.out_word), 32'h1555);
      check("bp_valid", 32'(sif.out_valid), 32'h1);
    end
    sif.out_ready = 1'b1;
    tick();
    check("bp_accept", 32'(sif.out_valid), 32'h0);
    tick();
    check("bp_nodup", 32'(sif.out_valid), 32'h0);

    // Overrun while the output is stalled
    do_reset();
    sif.out_ready = 1'b0;
    upd(0, 12'h001); tick(); idle(); tick();
    upd(3, 12'h00A); tick(); idle();
    upd(3, 12'h00B); tick(); idle();
    check("ovr_set", 32'(overrun), 32'h8);
    sif.out_ready = 1'b1;
    tick();
    check("ovr_word", 32'(sif.out_word), 32'h300B);
    tick();
    clr_overrun = 1'b1; tick(); idle();
    check("ovr_clr", 32'(overrun), 32'h0);

    // Same-edge update and grant
    do_reset();
    upd(1, 12'h100); tick(); idle();
    upd(1, 12'h200); tick(); idle();
    check("same_first", 32'(sif.out_word), 32'h1100);
    tick();
    check("same_second", 32'(sif.out_word), 32'h1200);
    check("same_noovr",  32'(overrun), 32'h0);
    tick();

    // Refresh then mid-transfer reset
    do_reset();
    upd(0, 12'h0A0); upd(1, 12'h1B1); upd(2, 12'h2C2); upd(3, 12'h3D3);
    tick(); idle();
    for (int i = 0; i < 5; i++) tick();
    refresh = 1'b1; tick(); idle();
    exp_words = '{16'h00A0, 16'h11B1, 16'h22C2, 16'h33D3};
    for (int i = 0; i < 4; i++) begin
      tick();
      check("refr_word", 32'(sif.out_word), 32'(exp_words[i]));
    end
    refresh = 1'b1; tick(); idle(); tick();
    check("refr_valid", 32'(sif.out_valid), 32'h1);
    rst = 1'b1; tick(); rst = 1'b0;
    check("mid_rst_valid", 32'(sif.out_valid), 32'h0);
    check("mid_rst_word",  32'(sif.out_word), 32'h0);
    check("mid_rst_busy",  32'(busy), 32'h0);

    // Randomized phase against the model
    for (int c = 0; c < 400; c++) begin
      ch_data       = {16'($urandom), $urandom};
      ch_upd        = ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'h0;
      sif.out_ready = ($urandom_range(0, 3) != 0);
      refresh       = ($urandom_range(0, 19) == 0);
      clr_overrun   = ($urandom_range(0, 9) == 0);
      rst           = ($urandom_range(0, 99) == 0);
      tick();
    end
    idle();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
